// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// fetch_queue_pkg : sizing helpers shared by the fetch unit and its buffer.
// Rev 1.0
// ============================================================================
package fetch_queue_pkg;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy needs one extra bit so that "full" (== depth) is representable.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return ptr_width(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// fetch_queue_if : memory-port and decoder-side signals of the fetch unit.
// Rev 1.0
// ============================================================================
interface fetch_queue_if #(
   parameter int W  = 16,
   parameter int AW = 16
);
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic [W-1:0]  mem_rdata;
   logic [W-1:0]  iw;
   logic [AW-1:0] iw_pc;
   logic          iw_valid;
   logic          iw_ready;
   logic          jump_en;
   logic [AW-1:0] jump_addr;

   modport master (
      output mem_req, mem_addr, iw, iw_pc, iw_valid,
      input  mem_gnt, mem_rdata, iw_ready, jump_en, jump_addr
   );

   modport slave (
      input  mem_req, mem_addr, iw, iw_pc, iw_valid,
      output mem_gnt, mem_rdata, iw_ready, jump_en, jump_addr
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_fifo_sync.sv
`default_nettype none
// ============================================================================
// fifo_sync : DEPTH x WIDTH circular buffer with occupancy count and flush.
// Rev 1.0
// ============================================================================
module fifo_sync
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   input  wire logic                     flush,
   input  wire logic                     push,
   input  wire logic [WIDTH-1:0]         push_data,
   input  wire logic                     pop,
   output logic      [WIDTH-1:0]         head_data,
   output logic      [cnt_width(DEPTH)-1:0] count,
   output logic                          empty
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             w_wr;
   logic             w_rd;
   logic [WIDTH-1:0] w_rd_arr [DEPTH];

   // Flush wins over a same-cycle push so no stale word survives a redirect.
   assign w_wr = push & ~flush;
   assign w_rd = pop & ~flush & (count_q != '0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_wr) tail_d = tail_q + 1'b1;
         if (w_rd) head_d = head_q + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] entry_q, entry_d;

      always_comb begin
         entry_d = entry_q;
         if (w_wr && (tail_q == PW'(i))) entry_d = push_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) entry_q <= '0;
         else        entry_q <= entry_d;
      end

      assign w_rd_arr[i] = entry_q;
   end

   assign head_data = w_rd_arr[head_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : sequential instruction fetch with a DEPTH-word prefetch queue.
// Rev 1.0
// ============================================================================
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int            W          = 16,
   parameter int            AW         = 16,
   parameter int            DEPTH      = 2,
   parameter logic [AW-1:0] RESET_ADDR = '0
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   fetch_queue_if.master bus
);

   localparam int            CW      = cnt_width(DEPTH);
   localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);

   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
   logic            inflight_q, inflight_d;
   logic [AW-1:0]   inflight_pc_q, inflight_pc_d;

   logic [CW-1:0]   w_count;
   logic            w_empty;
   logic [W+AW-1:0] w_head;
   logic            w_valid;
   logic            w_pop;
   logic            w_squash;
   logic            w_push;
   logic [CW:0]     w_used;
   logic            w_req;
   logic            w_accept;

   assign w_valid = ~w_empty;
   assign w_pop   = w_valid & bus.iw_ready;

   // A redirect discards whatever response lands in the same cycle.
   assign w_squash = bus.jump_en;
   assign w_push   = inflight_q & ~w_squash;

   // Credit: buffered + in-flight words after this cycle's pop must leave room.
   assign w_used   = {1'b0, w_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, w_pop};
   assign w_req    = rst_n & ~bus.jump_en & (w_used < C_DEPTH);
   assign w_accept = w_req & bus.mem_gnt;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = w_accept;
      inflight_pc_d = inflight_pc_q;
      if (bus.jump_en) begin
         fetch_pc_d = bus.jump_addr;
      end else if (w_accept) begin
         fetch_pc_d    = fetch_pc_q + 1'b1;
         inflight_pc_d = fetch_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_ADDR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (W + AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.jump_en),
      .push      (w_push),
      .push_data ({bus.mem_rdata, inflight_pc_q}),
      .pop       (w_pop),
      .head_data (w_head),
      .count     (w_count),
      .empty     (w_empty)
   );

   assign bus.mem_req  = w_req;
   assign bus.mem_addr = fetch_pc_q;
   assign bus.iw       = w_head[W+AW-1:AW];
   assign bus.iw_pc    = w_head[AW-1:0];
   assign bus.iw_valid = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : vector table plus scoreboard bench for fetch_queue.
// Rev 1.0
// ============================================================================
module tb_fetch_queue;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fetch_queue_if #(.W(16), .AW(16)) bus ();

   fetch_queue #(
      .W          (16),
      .AW         (16),
      .DEPTH      (4),
      .RESET_ADDR (16'h0100)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        ready;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [15:0] exp_pc;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb[$];
   logic [15:0] delivered[$];
   logic [15:0] model_pc;
   logic        s_req, s_valid;
   logic [15:0] s_addr, s_pc, s_iw;
   vec_t        vecs[15];

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive, sample mid-cycle, score, then answer the memory port.
   task automatic step(input logic gnt, input logic ready, input logic jmp, input logic [15:0] jaddr);
      logic        acc;
      logic [15:0] a;
      bus.mem_gnt   = gnt;
      bus.iw_ready  = ready;
      bus.jump_en   = jmp;
      bus.jump_addr = jaddr;
      #1;
      s_req   = bus.mem_req;
      s_addr  = bus.mem_addr;
      s_valid = bus.iw_valid;
      s_pc    = bus.iw_pc;
      s_iw    = bus.iw;
      acc     = s_req & gnt;
      a       = s_addr;
      if (s_req) chk("mem_addr_model", {16'h0, s_addr}, {16'h0, model_pc});
      if (jmp) chk("req_in_jump", {31'h0, s_req}, 32'h0);
      if (s_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL iw_unexpected: got pc %0h with no word outstanding", s_pc);
         end else begin
            chk("iw_head", {s_pc, s_iw}, sb[0]);
         end
         if (ready) begin
            delivered.push_back(s_pc);
            if (sb.size() > 0) sb.delete(0);
         end
      end
      if (jmp) begin
         sb.delete();
         model_pc = jaddr;
      end else if (acc) begin
         sb.push_back({a, word_of(a)});
         model_pc = a + 16'h1;
      end
      @(posedge clk);
      #1;
      bus.mem_rdata = acc ? word_of(a) : 16'($urandom_range(0, 65535));
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.mem_gnt   = 1'b0;
      bus.iw_ready  = 1'b0;
      bus.jump_en   = 1'b0;
      bus.jump_addr = '0;
      bus.mem_rdata = 16'hDEAD;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_iw_valid", {31'h0, bus.iw_valid}, 32'h0);
      chk("rst_iw",       {16'h0, bus.iw},       32'h0);
      chk("rst_iw_pc",    {16'h0, bus.iw_pc},    32'h0);
      chk("rst_mem_req",  {31'h0, bus.mem_req},  32'h0);
      chk("rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0100);
      rst_n    = 1'b1;
      sb.delete();
      delivered.delete();
      model_pc = 16'h0100;
   endtask

   initial begin
      // Reset release, then a 6-cycle decoder stall that fills all 4 entries.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0102, 1'b1, 16'h0100};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0103, 1'b1, 16'h0101};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h0104, 1'b1, 16'h0102};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0105, 1'b1, 16'h0102};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0106, 1'b1, 16'h0102};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0106, 1'b1, 16'h0102};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0106, 1'b1, 16'h0102};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0106, 1'b1, 16'h0102};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0106, 1'b1, 16'h0102};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0107, 1'b1, 16'h0103};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0108, 1'b1, 16'h0104};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h0109, 1'b1, 16'h0105};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 16'h010A, 1'b1, 16'h0106};

      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].gnt, vecs[i].ready, 1'b0, 16'h0);
         chk($sformatf("vec%0d_req", i),   {31'h0, s_req},   {31'h0, vecs[i].exp_req});
         chk($sformatf("vec%0d_addr", i),  {16'h0, s_addr},  {16'h0, vecs[i].exp_addr});
         chk($sformatf("vec%0d_valid", i), {31'h0, s_valid}, {31'h0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) chk($sformatf("vec%0d_pc", i), {16'h0, s_pc}, {16'h0, vecs[i].exp_pc});
      end

      // Redirect with 2 buffered words and one request in flight.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 1'b1, 16'h0200);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("jmp_t1_valid", {31'h0, s_valid}, 32'h0);
      chk("jmp_t1_req",   {31'h0, s_req},   32'h1);
      chk("jmp_t1_addr",  {16'h0, s_addr},  32'h0200);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("jmp_t2_valid", {31'h0, s_valid}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("jmp_t3_valid", {31'h0, s_valid}, 32'h1);
      chk("jmp_t3_pc",    {16'h0, s_pc},    32'h0200);

      // Back-to-back redirects: the second target wins.
      step(1'b1, 1'b1, 1'b1, 16'h0300);
      step(1'b1, 1'b1, 1'b1, 16'h0400);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("b2b_addr", {16'h0, s_addr}, 32'h0400);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("b2b_pc", {16'h0, s_pc}, 32'h0400);

      // Alternating grant, then drain with grant withheld.
      for (int i = 0; i < 16; i++) step(i[0], 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("drain_sb",    sb.size(),        32'h0);
      chk("drain_valid", {31'h0, s_valid}, 32'h0);

      // Address wrap at the top of the space.
      step(1'b1, 1'b1, 1'b1, 16'hFFFE);
      delivered.delete();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
      if (delivered.size() < 3) begin
         n_checks++;
         n_fail++;
         $display("FAIL wrap_count: got %0d words required at least 3", delivered.size());
      end else begin
         chk("wrap_pc0", {16'h0, delivered[0]}, 32'hFFFE);
         chk("wrap_pc1", {16'h0, delivered[1]}, 32'hFFFF);
         chk("wrap_pc2", {16'h0, delivered[2]}, 32'h0000);
      end

      // Asynchronous reset mid-stream.
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_valid", {31'h0, bus.iw_valid}, 32'h0);
      chk("areset_req",   {31'h0, bus.mem_req},  32'h0);
      chk("areset_addr",  {16'h0, bus.mem_addr}, 32'h0100);
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      sb.delete();
      delivered.delete();
      model_pc = 16'h0100;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
      if (delivered.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL areset_restart: got no words required pc 0100 first");
      end else begin
         chk("areset_first_pc", {16'h0, delivered[0]}, 32'h0100);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
